// File: rtl/wb_stage_pkg.sv
// Shared control-bundle layout, memory-size encodings and helpers for the write-back stage.
// Holds the CTRL_* bit indices that the other pipeline stages pack into the control bundle.
package wb_stage_pkg;

  localparam int CONTROL_SIGNALS_WIDTH = 10;

  localparam int CTRL_REG_WRITE    = 0;
  localparam int CTRL_MEM_TO_REG   = 1;
  localparam int CTRL_JUMP         = 2;
  localparam int CTRL_MEM_SIZE_LO  = 3;
  localparam int CTRL_MEM_SIZE_HI  = 4;
  localparam int CTRL_MEM_UNSIGNED = 5;
  localparam int CTRL_MEM_READ     = 6;
  localparam int CTRL_MEM_WRITE    = 7;
  localparam int CTRL_BRANCH       = 8;
  localparam int CTRL_ALU_SRC      = 9;

  typedef enum logic [1:0] {
    MEM_SIZE_WORD = 2'b00,
    MEM_SIZE_BYTE = 2'b01,
    MEM_SIZE_HALF = 2'b10,
    MEM_SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10
  } wb_sel_e;

  // Widen a byte or halfword (held in the low bits of field) to 32 bits.
  function automatic logic [31:0] extendField(input logic [15:0] field,
                                              input logic isByte,
                                              input logic isUnsigned);
    logic [31:0] result;
    if (isByte) begin
      result = {{24{~isUnsigned & field[7]}}, field[7:0]};
    end else begin
      result = {{16{~isUnsigned & field[15]}}, field[15:0]};
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment: picks the addressed byte/halfword from the raw memory word
// and sign- or zero-extends it; word and reserved sizes pass the word unchanged.
module wb_load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  mem_size_e   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  // Halfword offset bit 0 is ignored; misaligned halves are trapped before this stage.
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_size)
      MEM_SIZE_BYTE: o_data = extendField({8'h00, w_byte}, 1'b1, i_unsigned);
      MEM_SIZE_HALF: o_data = extendField(w_half, 1'b0, i_unsigned);
      default:       o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage: write-back mux, register-file write port and one-cycle
// write record for the WB-to-ID bypass. Define WB_RETIRE_CNT_EN to add the instret counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mem_wb_valid,
  input  logic [XLEN-1:0]                  mem_wb_alu_result,
  input  logic [XLEN-1:0]                  mem_wb_mem_data,
  input  logic [XLEN-1:0]                  mem_wb_pc_plus4,
  input  logic [4:0]                       mem_wb_rd,
  input  logic [CONTROL_SIGNALS_WIDTH-1:0] mem_wb_control_signals,
  output logic [XLEN-1:0]                  wb_data,
  output logic                             rf_we,
  output logic [4:0]                       rf_waddr,
  output logic                             wb_last_we,
  output logic [4:0]                       wb_last_rd,
  output logic [XLEN-1:0]                  wb_last_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]                      instret
`endif
);

  logic            w_regWrite;
  logic            w_memToReg;
  logic            w_jump;
  logic            w_memUnsigned;
  mem_size_e       w_memSize;
  wb_sel_e         w_sel;
  logic [XLEN-1:0] w_loadData;
  logic [XLEN-1:0] w_wbData;
  logic            w_rfWe;
  logic            w_unusedCtrl;

  logic            r_lastWe;
  logic [4:0]      r_lastRd;
  logic [XLEN-1:0] r_lastData;

  assign w_regWrite    = mem_wb_control_signals[CTRL_REG_WRITE];
  assign w_memToReg    = mem_wb_control_signals[CTRL_MEM_TO_REG];
  assign w_jump        = mem_wb_control_signals[CTRL_JUMP];
  assign w_memUnsigned = mem_wb_control_signals[CTRL_MEM_UNSIGNED];
  assign w_memSize     = mem_size_e'(mem_wb_control_signals[CTRL_MEM_SIZE_HI:CTRL_MEM_SIZE_LO]);

  // Memory-stage and execute-stage fields travel in the bundle but are not needed here.
  assign w_unusedCtrl  = ^{mem_wb_control_signals[CTRL_MEM_READ],
                           mem_wb_control_signals[CTRL_MEM_WRITE],
                           mem_wb_control_signals[CTRL_BRANCH],
                           mem_wb_control_signals[CTRL_ALU_SRC]};

  wb_load_align u_loadAlign (
    .i_word     (mem_wb_mem_data),
    .i_offset   (mem_wb_alu_result[1:0]),
    .i_size     (w_memSize),
    .i_unsigned (w_memUnsigned),
    .o_data     (w_loadData)
  );

  // A jump overrides MEM_TO_REG so JAL/JALR always link PC+4.
  always_comb begin
    w_sel = WB_SEL_ALU;
    if (w_jump) begin
      w_sel = WB_SEL_PC4;
    end else if (w_memToReg) begin
      w_sel = WB_SEL_LOAD;
    end
  end

  always_comb begin
    w_wbData = mem_wb_alu_result;
    case (w_sel)
      WB_SEL_PC4:  w_wbData = mem_wb_pc_plus4;
      WB_SEL_LOAD: w_wbData = w_loadData;
      default:     w_wbData = mem_wb_alu_result;
    endcase
  end

  assign w_rfWe   = mem_wb_valid & w_regWrite & (mem_wb_rd != 5'd0);
  assign wb_data  = w_wbData;
  assign rf_we    = w_rfWe;
  assign rf_waddr = mem_wb_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastWe   <= 1'b0;
      r_lastRd   <= 5'd0;
      r_lastData <= '0;
    end else begin
      r_lastWe   <= w_rfWe;
      r_lastRd   <= mem_wb_rd;
      r_lastData <= w_wbData;
    end
  end

  assign wb_last_we   = r_lastWe;
  assign wb_last_rd   = r_lastRd;
  assign wb_last_data = r_lastData;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_instret;

  // Counts every real instruction reaching write-back, including ones that write nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= 64'd0;
    end else if (mem_wb_valid) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: fixed vector table, hand-written record/reset
// sequences and a randomized run against a behavioural model.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int CW = CONTROL_SIGNALS_WIDTH;

  logic          clk;
  logic          rst;
  logic          memWbValid;
  logic [31:0]   memWbAluResult;
  logic [31:0]   memWbMemData;
  logic [31:0]   memWbPcPlus4;
  logic [4:0]    memWbRd;
  logic [CW-1:0] memWbCtrl;
  logic [31:0]   wbData;
  logic          rfWe;
  logic [4:0]    rfWaddr;
  logic          wbLastWe;
  logic [4:0]    wbLastRd;
  logic [31:0]   wbLastData;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]   instret;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage #(.XLEN(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_wb_valid           (memWbValid),
    .mem_wb_alu_result      (memWbAluResult),
    .mem_wb_mem_data        (memWbMemData),
    .mem_wb_pc_plus4        (memWbPcPlus4),
    .mem_wb_rd              (memWbRd),
    .mem_wb_control_signals (memWbCtrl),
    .wb_data                (wbData),
    .rf_we                  (rfWe),
    .rf_waddr               (rfWaddr),
    .wb_last_we             (wbLastWe),
    .wb_last_rd             (wbLastRd),
    .wb_last_data           (wbLastData)
`ifdef WB_RETIRE_CNT_EN
    ,
    .instret                (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memToReg;
    logic        jump;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] expData;
    logic        expWe;
  } vector_t;

  function automatic logic [CW-1:0] makeCtrl(input logic regWrite, input logic memToReg,
                                             input logic jump, input logic [1:0] size,
                                             input logic uns);
    logic [CW-1:0] c;
    c = '0;
    c[CTRL_REG_WRITE]    = regWrite;
    c[CTRL_MEM_TO_REG]   = memToReg;
    c[CTRL_JUMP]         = jump;
    c[CTRL_MEM_SIZE_LO]  = size[0];
    c[CTRL_MEM_SIZE_HI]  = size[1];
    c[CTRL_MEM_UNSIGNED] = uns;
    return c;
  endfunction

  // Reference: shift/mask arithmetic on the architectural load rules.
  function automatic logic [31:0] modelWbData(input logic [31:0] alu, input logic [31:0] mem,
                                              input logic [31:0] pc4, input logic [CW-1:0] ctrl);
    int unsigned off;
    int unsigned sizeCode;
    logic [31:0] v;
    if (ctrl[CTRL_JUMP]) return pc4;
    if (!ctrl[CTRL_MEM_TO_REG]) return alu;
    off = alu % 4;
    sizeCode = {30'd0, ctrl[CTRL_MEM_SIZE_HI], ctrl[CTRL_MEM_SIZE_LO]};
    if (sizeCode == 1) begin
      v = (mem >> (8 * off)) & 32'd255;
      if (!ctrl[CTRL_MEM_UNSIGNED] && v >= 32'd128) v = v - 32'd256;
    end else if (sizeCode == 2) begin
      v = (mem >> (16 * (off / 2))) & 32'd65535;
      if (!ctrl[CTRL_MEM_UNSIGNED] && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = mem;
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] alu, input logic [31:0] mem,
                               input logic [31:0] pc4, input logic [4:0] rd,
                               input logic [CW-1:0] ctrl);
    memWbValid     = valid;
    memWbAluResult = alu;
    memWbMemData   = mem;
    memWbPcPlus4   = pc4;
    memWbRd        = rd;
    memWbCtrl      = ctrl;
  endtask

  vector_t vectors[$];
  logic [31:0] expData;
  logic        expWe;
  logic        expLastWe;
  logic [4:0]  expLastRd;
  logic [31:0] expLastData;
  longint unsigned expInstret;
  logic [CW-1:0] rCtrl;

  initial begin
    vectors.push_back('{"allZeroCtrl",  1, 32'hDEADBEEF, 32'hCAFEBABE, 32'h0, 5'd3, 0, 0, 0, 2'b00, 0, 32'hDEADBEEF, 0});
    vectors.push_back('{"loadWord",     1, 32'hDEADBEEF, 32'hCAFEBABE, 32'h0, 5'd3, 0, 1, 0, 2'b00, 0, 32'hCAFEBABE, 0});
    vectors.push_back('{"aluNoWrite",   1, 32'h12345678, 32'h87654321, 32'h0, 5'd4, 0, 0, 0, 2'b00, 0, 32'h12345678, 0});
    vectors.push_back('{"memNoWrite",   1, 32'h12345678, 32'h87654321, 32'h0, 5'd4, 0, 1, 0, 2'b00, 0, 32'h87654321, 0});
    vectors.push_back('{"lbOff0",       1, 32'h00000000, 32'h80F17F80, 32'h0, 5'd6, 1, 1, 0, 2'b01, 0, 32'hFFFFFF80, 1});
    vectors.push_back('{"lbuOff1",      1, 32'h00000001, 32'h80F17F80, 32'h0, 5'd6, 1, 1, 0, 2'b01, 1, 32'h0000007F, 1});
    vectors.push_back('{"lbuOff2",      1, 32'h00000002, 32'h80F17F80, 32'h0, 5'd6, 1, 1, 0, 2'b01, 1, 32'h000000F1, 1});
    vectors.push_back('{"lbOff3",       1, 32'h00000003, 32'h80F17F80, 32'h0, 5'd6, 1, 1, 0, 2'b01, 0, 32'hFFFFFF80, 1});
    vectors.push_back('{"lhOff2",       1, 32'h00000002, 32'h80F17F80, 32'h0, 5'd6, 1, 1, 0, 2'b10, 0, 32'hFFFF80F1, 1});
    vectors.push_back('{"lhuOff2",      1, 32'h00000002, 32'h80F17F80, 32'h0, 5'd6, 1, 1, 0, 2'b10, 1, 32'h000080F1, 1});
    vectors.push_back('{"lhOff3",       1, 32'h00000003, 32'h80F17F80, 32'h0, 5'd6, 1, 1, 0, 2'b10, 0, 32'hFFFF80F1, 1});
    vectors.push_back('{"lhOff0",       1, 32'h00000000, 32'h80F17F80, 32'h0, 5'd6, 1, 1, 0, 2'b10, 0, 32'h00007F80, 1});
    vectors.push_back('{"sizeRsvd",     1, 32'h00000003, 32'h80F17F80, 32'h0, 5'd6, 1, 1, 0, 2'b11, 0, 32'h80F17F80, 1});
    vectors.push_back('{"jumpWins",     1, 32'h00000010, 32'h80F17F80, 32'h00000104, 5'd1, 1, 1, 1, 2'b00, 0, 32'h00000104, 1});
    vectors.push_back('{"weRd5",        1, 32'h00000055, 32'h0, 32'h0, 5'd5, 1, 0, 0, 2'b00, 0, 32'h00000055, 1});
    vectors.push_back('{"weRd0",        1, 32'h00000055, 32'h0, 32'h0, 5'd0, 1, 0, 0, 2'b00, 0, 32'h00000055, 0});
    vectors.push_back('{"weBubble",     0, 32'h00000055, 32'h0, 32'h0, 5'd5, 1, 0, 0, 2'b00, 0, 32'h00000055, 0});

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, '0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetLastWe", {63'd0, wbLastWe}, 64'd0);
    checkOutput("resetLastRd", {59'd0, wbLastRd}, 64'd0);
    checkOutput("resetLastData", {32'd0, wbLastData}, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    checkOutput("resetInstret", instret, 64'd0);
`endif
    rst = 1'b0;

    foreach (vectors[i]) begin
      applyStimulus(vectors[i].valid, vectors[i].alu, vectors[i].mem, vectors[i].pc4, vectors[i].rd,
                    makeCtrl(vectors[i].regWrite, vectors[i].memToReg, vectors[i].jump,
                             vectors[i].size, vectors[i].uns));
      #2;
      checkOutput({vectors[i].name, ".wbData"}, {32'd0, wbData}, {32'd0, vectors[i].expData});
      checkOutput({vectors[i].name, ".rfWe"}, {63'd0, rfWe}, {63'd0, vectors[i].expWe});
      checkOutput({vectors[i].name, ".rfWaddr"}, {59'd0, rfWaddr}, {59'd0, vectors[i].rd});
    end

    @(negedge clk);
    applyStimulus(1'b1, 32'h00001234, 32'h0, 32'h0, 5'd7, makeCtrl(1, 0, 0, 2'b00, 0));
    @(posedge clk);
    #1;
    checkOutput("recordWe", {63'd0, wbLastWe}, 64'd1);
    checkOutput("recordRd", {59'd0, wbLastRd}, 64'd7);
    checkOutput("recordData", {32'd0, wbLastData}, 64'h1234);

    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("wbDataInReset", {32'd0, wbData}, 64'h1234);
    checkOutput("rfWeInReset", {63'd0, rfWe}, 64'd1);
    @(posedge clk);
    #1;
    checkOutput("rstClearsWe", {63'd0, wbLastWe}, 64'd0);
    checkOutput("rstClearsRd", {59'd0, wbLastRd}, 64'd0);
    checkOutput("rstClearsData", {32'd0, wbLastData}, 64'd0);

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef WB_RETIRE_CNT_EN
    checkOutput("instretAfter3", instret, 64'd3);
`endif
    @(negedge clk);
    memWbValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("bubbleLastWe", {63'd0, wbLastWe}, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    checkOutput("bubbleInstret", instret, 64'd3);
`endif

    expInstret = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst = (i == 0) || ($urandom_range(0, 15) == 0);
      rCtrl = CW'($urandom);
      applyStimulus(($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom,
                    ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), rCtrl);
      #1;
      expData = modelWbData(memWbAluResult, memWbMemData, memWbPcPlus4, memWbCtrl);
      expWe   = memWbValid && memWbCtrl[CTRL_REG_WRITE] && (memWbRd != 0);
      checkOutput("randWbData", {32'd0, wbData}, {32'd0, expData});
      checkOutput("randRfWe", {63'd0, rfWe}, {63'd0, expWe});
      checkOutput("randRfWaddr", {59'd0, rfWaddr}, {59'd0, memWbRd});
      if (rst) begin
        expLastWe = 1'b0; expLastRd = 5'd0; expLastData = 32'd0; expInstret = 0;
      end else begin
        expLastWe = expWe; expLastRd = memWbRd; expLastData = expData;
        if (memWbValid) expInstret = expInstret + 1;
      end
      @(posedge clk);
      #1;
      checkOutput("randLastWe", {63'd0, wbLastWe}, {63'd0, expLastWe});
      checkOutput("randLastRd", {59'd0, wbLastRd}, {59'd0, expLastRd});
      checkOutput("randLastData", {32'd0, wbLastData}, {32'd0, expLastData});
`ifdef WB_RETIRE_CNT_EN
      checkOutput("randInstret", instret, expInstret);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the 5-stage RV32I pipeline. It takes the MEM/WB pipeline register contents and selects the write-back value: ALU result, load data (size/sign adjusted) or PC+4 for jumps. It drives the register-file write port and keeps a one-cycle write record used for the WB-to-ID bypass. Write-back selection is purely combinational. Clock and reset only touch the write record and the optional retire counter.

Parameters:
XLEN, 32, datapath width; all data ports use it. Only 32 is supported.

Ports:
clk  in  1  pipeline clock
rst  in  1  reset; one clock, reset is synchronous and active-high
mem_wb_valid  in  1  MEM/WB slot holds a real instruction (0 = bubble)
mem_wb_alu_result  in  32  ALU result; bits [1:0] give the load byte offset
mem_wb_mem_data  in  32  raw 32-bit word read from data memory
mem_wb_pc_plus4  in  32  PC+4 of the instruction
mem_wb_rd  in  5  destination register index
mem_wb_control_signals  in  `CONTROL_SIGNALS_WIDTH  control bundle from constants.v
wb_data  out  32  selected write-back value (combinational)
rf_we  out  1  register-file write enable (combinational)
rf_waddr  out  5  register-file write index (= mem_wb_rd)
wb_last_we  out  1  registered rf_we of the previous cycle
wb_last_rd  out  5  registered rf_waddr of the previous cycle
wb_last_data  out  32  registered wb_data of the previous cycle

Behaviour:
- Control fields used: CTRL_MEM_TO_REG, CTRL_REG_WRITE, CTRL_JUMP, CTRL_MEM_SIZE[1:0] (00 word, 01 byte, 10 half, 11 treated as word), CTRL_MEM_UNSIGNED. An all-zero bundle means ALU result, word, signed, no write.
- Selection priority:
  - CTRL_JUMP=1: wb_data = mem_wb_pc_plus4.
  - else CTRL_MEM_TO_REG=1: wb_data = load_data.
  - else: wb_data = mem_wb_alu_result.
- load_data, with off = alu_result[1:0]:
  - word: mem_data unchanged.
  - byte: mem_data[8*off +: 8], sign-extended, or zero-extended if CTRL_MEM_UNSIGNED.
  - half: mem_data[16*off[1] +: 16], extended the same way; off[0] is ignored (misalignment is trapped upstream).
- wb_data depends only on the data inputs and control fields. It ignores CTRL_REG_WRITE, mem_wb_valid, clk and rst, and it is valid while rst is asserted.
- rf_we = mem_wb_valid & CTRL_REG_WRITE & (mem_wb_rd != 0). Writes to x0 are always suppressed.
- rf_waddr = mem_wb_rd unconditionally.
- Write record: on each rising clk, wb_last_we <= rf_we, wb_last_rd <= rf_waddr, wb_last_data <= wb_data. Latency is 1 cycle.
- Reset: when rst is high at a clock edge, wb_last_we=0, wb_last_rd=0 and wb_last_data=0, overriding any concurrent capture. A reset mid-stream discards the pending record.
- No handshake and no stall input. A stall is modelled upstream by feeding a bubble (mem_wb_valid=0), which forces rf_we=0 and wb_last_we=0 on the next edge.

Optional Feature:
WB_RETIRE_CNT_EN:
- Defined: adds output instret (64 bits). It increments by 1 on each clk edge with mem_wb_valid=1, is cleared to 0 by rst, and wraps from 2^64-1 to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- constants.v (shared) owns CONTROL_SIGNALS_WIDTH and all CTRL_* bit and field indices, plus the MEM_SIZE encodings.
- One natural sub-module: wb_load_align (combinational size, offset and sign extension). The top level holds the mux, the write-enable logic and the registers.

Test Plan:
1. Bundle all zero, valid=1, alu=0xDEADBEEF, mem=0xCAFEBABE -> wb_data=0xDEADBEEF, rf_we=0.
2. MEM_TO_REG=1 word, same data -> wb_data=0xCAFEBABE. Repeat with REG_WRITE=0, alu=0x12345678, mem=0x87654321 -> 0x12345678 with MEM_TO_REG=0, and 0x87654321 with MEM_TO_REG=1.
3. Load extension, mem=0x80F17F80:
   - byte, off=0, signed -> 0xFFFFFF80.
   - byte, off=1, unsigned -> 0x0000007F.
   - half, off=2, signed -> 0xFFFF80F1.
   - half, off=2, unsigned -> 0x000080F1.
4. JUMP=1, MEM_TO_REG=1, pc_plus4=0x00000104 -> wb_data=0x00000104.
5. Write enable: REG_WRITE=1, valid=1, rd=5 -> rf_we=1. rd=0 -> rf_we=0. valid=0 -> rf_we=0.
6. Write record: clock rd=7, data=0x1234 -> next cycle wb_last_we=1, rd=7, data=0x1234. Assert rst with rf_we=1 for one edge -> all three cleared. With WB_RETIRE_CNT_EN defined, 3 valid cycles after reset give instret=3.
